// File: rtl/lfl1402_line_peak_if.sv
// Sensor-side inputs and line-feature results of the LFL1402 line peak reducer.
interface lfl1402_line_peak_if #(
    parameter int unsigned DW = 8
) ();
    logic          clk_lfl1402;
    logic          clk_st_lfl1402;
    logic [DW-1:0] adc_data;
    logic [DW-1:0] thr;
    logic [DW-1:0] peak_val;
    logic [7:0]    peak_idx;
    logic [7:0]    above_cnt;
    logic [7:0]    first_idx;
    logic [7:0]    last_idx;
    logic          result_valid;
    logic          line_short;

    modport master (
        output clk_lfl1402, clk_st_lfl1402, adc_data, thr,
        input  peak_val, peak_idx, above_cnt, first_idx, last_idx, result_valid, line_short
    );

    modport slave (
        input  clk_lfl1402, clk_st_lfl1402, adc_data, thr,
        output peak_val, peak_idx, above_cnt, first_idx, last_idx, result_valid, line_short
    );
endinterface

// File: rtl/lfl1402_line_peak.sv
// Samples the LFL1402 video ADC once per pixel and reduces each line to
// peak value/index, above-threshold count and first/last above-threshold index.
module lfl1402_line_peak #(
    parameter int unsigned NPIX       = 128,
    parameter int unsigned SAMPLE_DLY = 20,
    parameter int unsigned DW         = 8
) (
    input  logic clk,
    input  logic rst,
    lfl1402_line_peak_if.slave bus
);

    localparam int unsigned IW = 8;
    localparam int unsigned CW = (SAMPLE_DLY > 1) ? $clog2(SAMPLE_DLY) : 1;
    localparam logic [IW-1:0] LAST_PIX = IW'(NPIX - 1);
    localparam logic [CW-1:0] DLY_LOAD = CW'(SAMPLE_DLY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic          sclk_prev;
    logic          sclk_rise_c;
    logic          early_c;
    logic          start_c;
    logic          load_dly_c;
    logic          sample_c;
    logic          publish_c;

    logic [CW-1:0] dly_cnt;
    logic [IW-1:0] pix_idx;
    logic [IW-1:0] acc_max_idx;
    logic [IW-1:0] acc_cnt;
    logic [IW-1:0] acc_first;
    logic [IW-1:0] acc_last;
    logic [DW-1:0] acc_max;
    logic [DW-1:0] thr_lat;
    logic          seen_above;

    assign sclk_rise_c = bus.clk_lfl1402 & ~sclk_prev;

    // A start inside a line (after pixel 0 has been taken, or mid-sample) aborts it.
    assign early_c = sclk_rise_c & bus.clk_st_lfl1402 &
                     (((state == S_ARM) & (pix_idx != '0)) |
                      (state == S_WAIT) | (state == S_SAMPLE));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (sclk_rise_c && bus.clk_st_lfl1402) begin
                    state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                if (early_c) begin
                    state_nxt = S_ARM;
                end else if (sclk_rise_c && !bus.clk_st_lfl1402) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (early_c) begin
                    state_nxt = S_ARM;
                end else if (dly_cnt <= CW'(1)) begin
                    state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (early_c) begin
                    state_nxt = S_ARM;
                end else if (pix_idx == LAST_PIX) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_ARM;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath control strobes
    always_comb begin
        start_c    = 1'b0;
        load_dly_c = 1'b0;
        sample_c   = 1'b0;
        publish_c  = 1'b0;
        case (state)
            S_IDLE:   start_c    = sclk_rise_c & bus.clk_st_lfl1402;
            S_ARM:    load_dly_c = sclk_rise_c & ~bus.clk_st_lfl1402;
            S_SAMPLE: sample_c   = ~early_c;
            S_DONE:   publish_c  = 1'b1;
            default:  ;
        endcase
        if (early_c) begin
            start_c = 1'b1;
        end
    end

    // Accumulators, settling counter and registered results
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_prev        <= 1'b0;
            dly_cnt          <= '0;
            pix_idx          <= '0;
            acc_max          <= '0;
            acc_max_idx      <= '0;
            acc_cnt          <= '0;
            acc_first        <= '0;
            acc_last         <= '0;
            seen_above       <= 1'b0;
            thr_lat          <= '0;
            bus.peak_val     <= '0;
            bus.peak_idx     <= '0;
            bus.above_cnt    <= '0;
            bus.first_idx    <= '0;
            bus.last_idx     <= '0;
            bus.result_valid <= 1'b0;
            bus.line_short   <= 1'b0;
        end else begin
            sclk_prev        <= bus.clk_lfl1402;
            bus.result_valid <= publish_c;
            bus.line_short   <= early_c;

            if (start_c) begin
                thr_lat     <= bus.thr;
                pix_idx     <= '0;
                acc_max     <= '0;
                acc_max_idx <= '0;
                acc_cnt     <= '0;
                acc_first   <= '0;
                acc_last    <= '0;
                seen_above  <= 1'b0;
            end

            if (load_dly_c) begin
                dly_cnt <= DLY_LOAD;
            end else if ((state == S_WAIT) && (dly_cnt != '0)) begin
                dly_cnt <= dly_cnt - CW'(1);
            end

            if (sample_c) begin
                // Strict compare keeps the lowest index on ties.
                if ((bus.adc_data > acc_max) || (pix_idx == '0)) begin
                    acc_max     <= bus.adc_data;
                    acc_max_idx <= pix_idx;
                end
                if (bus.adc_data > thr_lat) begin
                    acc_cnt  <= acc_cnt + IW'(1);
                    acc_last <= pix_idx;
                    if (!seen_above) begin
                        acc_first  <= pix_idx;
                        seen_above <= 1'b1;
                    end
                end
                if (pix_idx != LAST_PIX) begin
                    pix_idx <= pix_idx + IW'(1);
                end
            end

            if (publish_c) begin
                bus.peak_val  <= acc_max;
                bus.peak_idx  <= acc_max_idx;
                bus.above_cnt <= acc_cnt;
                bus.first_idx <= acc_first;
                bus.last_idx  <= acc_last;
            end
        end
    end

endmodule

// File: tb/tb_lfl1402_line_peak.sv
// Scoreboard bench for lfl1402_line_peak: line stimulus pushes expected features,
// a negedge monitor pops and compares them whenever the DUT strobes an output.
`timescale 1ns/1ps
module tb_lfl1402_line_peak;

    localparam int NPIX       = 128;
    localparam int SAMPLE_DLY = 20;
    localparam int DW         = 8;
    localparam int SPER       = 50;

    typedef struct {
        int     kind;     // 0 result_valid, 1 line_short
        int     pv;
        int     pi;
        int     ac;
        int     fi;
        int     li;
        longint cyc;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    longint cyc = 0;
    int     errors = 0;
    int     checks = 0;

    exp_t   sb[$];
    exp_t   held;
    exp_t   mon;
    bit     abort_pending = 1'b0;
    logic [7:0] pix [NPIX];

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lfl1402_line_peak_if #(.DW(DW)) bus ();

    lfl1402_line_peak #(
        .NPIX(NPIX),
        .SAMPLE_DLY(SAMPLE_DLY),
        .DW(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: maximum, its first position, and the list of above-threshold positions.
    function automatic exp_t model_line(input int t);
        exp_t e;
        int   above[$];
        int   mx;
        mx = 0;
        foreach (pix[i]) if (int'(pix[i]) > mx) mx = int'(pix[i]);
        e.kind = 0;
        e.pv   = mx;
        e.pi   = -1;
        foreach (pix[i]) begin
            if (e.pi < 0 && int'(pix[i]) == mx) e.pi = i;
            if (int'(pix[i]) > t) above.push_back(i);
        end
        e.ac  = above.size();
        e.fi  = (above.size() > 0) ? above[0] : 0;
        e.li  = (above.size() > 0) ? above[$] : 0;
        e.cyc = 0;
        return e;
    endfunction

    // One sensor-clock period; the ADC level at rise+SAMPLE_DLY is the pixel value.
    task automatic period(input bit st, input logic [7:0] v, input bit junk,
                          input bit do_push, input exp_t e, input int offs);
        exp_t q;
        q = e;
        for (int c = 0; c < SPER; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                bus.clk_lfl1402    = 1'b1;
                bus.clk_st_lfl1402 = st;
                if (do_push) begin
                    q.cyc = cyc + longint'(offs);
                    sb.push_back(q);
                end
            end
            if (c == SPER / 2) bus.clk_lfl1402 = 1'b0;
            if (c == SAMPLE_DLY) bus.adc_data = v;
            else if (junk && (c == SAMPLE_DLY - 1 || c == SAMPLE_DLY + 1)) bus.adc_data = ~v;
            else if (junk) bus.adc_data = 8'($urandom_range(0, 255));
            else bus.adc_data = v;
        end
    endtask

    task automatic run_line(input int t, input int npx, input bit junk);
        exp_t e;
        exp_t s;
        s      = held;
        s.kind = 1;
        bus.thr = 8'(t);
        period(1'b1, 8'd0, junk, abort_pending, s, 1);
        abort_pending = 1'b0;
        e = model_line(t);
        for (int p = 0; p < npx; p++) begin
            if (p == 1) bus.thr = 8'($urandom_range(0, 255));
            period(1'b0, pix[p], junk, (p == NPIX - 1), e, SAMPLE_DLY + 2);
        end
        if (npx == NPIX) held = e;
        else abort_pending = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_peak_val"},  longint'(bus.peak_val), 0);
        chk({tag, "_peak_idx"},  longint'(bus.peak_idx), 0);
        chk({tag, "_above_cnt"}, longint'(bus.above_cnt), 0);
        chk({tag, "_first_idx"}, longint'(bus.first_idx), 0);
        chk({tag, "_last_idx"},  longint'(bus.last_idx), 0);
        chk({tag, "_valid"},     longint'(bus.result_valid), 0);
        chk({tag, "_short"},     longint'(bus.line_short), 0);
    endtask

    task automatic fill_rand();
        foreach (pix[i]) pix[i] = 8'($urandom_range(0, 255));
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst && (bus.result_valid || bus.line_short)) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", longint'({bus.result_valid, bus.line_short}), 0);
            end else begin
                mon = sb.pop_front();
                chk("kind", bus.line_short ? (bus.result_valid ? 2 : 1) : 0, mon.kind);
                chk("cycle", cyc, mon.cyc);
                chk("peak_val", longint'(bus.peak_val), mon.pv);
                chk("peak_idx", longint'(bus.peak_idx), mon.pi);
                chk("above_cnt", longint'(bus.above_cnt), mon.ac);
                chk("first_idx", longint'(bus.first_idx), mon.fi);
                chk("last_idx", longint'(bus.last_idx), mon.li);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        held = '{kind: 1, pv: 0, pi: 0, ac: 0, fi: 0, li: 0, cyc: 0};
        bus.clk_lfl1402    = 1'b0;
        bus.clk_st_lfl1402 = 1'b0;
        bus.adc_data       = '0;
        bus.thr            = '0;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero("reset");

        // Flat line below threshold
        foreach (pix[i]) pix[i] = 8'd10;
        run_line(50, NPIX, 1'b0);

        // Single spike
        foreach (pix[i]) pix[i] = 8'd5;
        pix[37] = 8'd200;
        run_line(100, NPIX, 1'b0);

        // Spot with a tie at the maximum
        foreach (pix[i]) pix[i] = 8'd20;
        pix[60] = 8'd120; pix[61] = 8'd180; pix[62] = 8'd250; pix[63] = 8'd250;
        pix[64] = 8'd190; pix[65] = 8'd130; pix[66] = 8'd90;
        run_line(100, NPIX, 1'b0);

        // Sample timing: neighbouring cycles carry the complement of the pixel value
        fill_rand();
        run_line($urandom_range(100, 240), NPIX, 1'b1);

        // Early start after pixel 80, then a complete line
        fill_rand();
        run_line($urandom_range(100, 240), 81, 1'b1);
        fill_rand();
        run_line($urandom_range(100, 240), NPIX, 1'b1);

        // Reset during pixel 50
        fill_rand();
        run_line($urandom_range(100, 240), 50, 1'b1);
        @(posedge clk); #1;
        bus.clk_lfl1402 = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.clk_lfl1402 = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        abort_pending = 1'b0;
        held = '{kind: 1, pv: 0, pi: 0, ac: 0, fi: 0, li: 0, cyc: 0};
        @(negedge clk);
        check_zero("midline_reset");
        repeat (SPER) @(posedge clk);
        #1;

        fill_rand();
        run_line($urandom_range(100, 240), NPIX, 1'b1);

        // Nothing above a maximal threshold
        fill_rand();
        run_line(255, NPIX, 1'b1);

        repeat (SPER) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
